// File: rtl/sym_serializer_pkg.sv
// Shared constants and state encoding for the symbol serializer.
package sym_ser_pkg;
    localparam int SYM_W = 5;
    localparam int LVL_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;
endpackage

// File: rtl/sym_serializer_if.sv
// Upstream symbol input and serial output bundle of sym_serializer.
interface sym_serializer_if;
    import sym_ser_pkg::*;

    logic [SYM_W-1:0] dmod;
    logic             mod_en;
    logic             ser_out;
    logic             ser_valid;
    logic             sym_start;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             overflow;

    modport master (
        output dmod, mod_en,
        input  ser_out, ser_valid, sym_start,
        input  level, full, overflow
    );

    modport slave (
        input  dmod, mod_en,
        output ser_out, ser_valid, sym_start,
        output level, full, overflow
    );
endinterface

// File: rtl/sym_fifo.sv
// Symbol FIFO with power-of-two depth; pointers wrap naturally.
module sym_fifo #(
    parameter int DEPTH = 8,
    parameter int SYM_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [SYM_W-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [SYM_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [AW:0]   L_ONE = (AW+1)'(1);
    localparam logic [AW:0]   L_MAX = (AW+1)'(DEPTH);

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + P_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + P_ONE;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + L_ONE;
            2'b01:   level_d = level_q - L_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;
    assign full    = (level_q == L_MAX);
    assign empty   = (level_q == '0);
endmodule

// File: rtl/sym_serializer.sv
// Buffers 5-bit symbols and shifts them out MSB first, CLK_DIV cycles/bit.
module sym_serializer
    import sym_ser_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    sym_serializer_if.slave  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [2:0]    BIT_LAST = 3'd4;

    ser_state_e       state_q, state_d;
    logic [SYM_W-1:0] sh_q, sh_d;
    logic [2:0]       bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             start_q, start_d;
    logic             ovf_q, ovf_d;
    logic             pop, push;

    logic [SYM_W-1:0]       fifo_rd;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   fifo_full;
    logic                   fifo_empty;

    sym_fifo #(
        .DEPTH (DEPTH),
        .SYM_W (SYM_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (bus.dmod),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO still accepts when the serializer frees a slot this cycle.
    assign push  = bus.mod_en && (!fifo_full || pop);
    assign ovf_d = ovf_q || (bus.mod_en && fifo_full && !pop);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        div_d   = div_q;
        start_d = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_rd;
                    bit_d   = '0;
                    div_d   = '0;
                    start_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (bit_q != BIT_LAST) begin
                        sh_d  = {sh_q[SYM_W-2:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                    end else if (!fifo_empty) begin
                        // Reload on the last bit cycle keeps symbols gapless.
                        pop     = 1'b1;
                        sh_d    = fifo_rd;
                        bit_d   = '0;
                        start_d = 1'b1;
                    end else begin
                        sh_d    = '0;
                        bit_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.ser_out   = (state_q == SHIFT) && sh_q[SYM_W-1];
    assign bus.sym_start = start_q;
    assign bus.level     = LVL_W'(fifo_level);
    assign bus.full      = fifo_full;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sym_serializer.sv
// Directed and burst checks of sym_serializer against a queue-based model.
module tb_sym_serializer;
    import sym_ser_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 2;
    localparam int SYMC    = 5 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sym_serializer_if bus ();

    sym_serializer #(
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model: FIFO contents, symbol on the wire, cycles left on it.
    logic [4:0] fq[$];
    logic [4:0] popped[$];
    logic [4:0] cur;
    int         busy;
    bit         m_ovf;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit wr;
        if (rst) begin
            fq.delete();
            busy  = 0;
            cur   = '0;
            m_ovf = 1'b0;
        end else begin
            pop = (busy <= 1) && (fq.size() > 0);
            wr  = bus.mod_en && ((fq.size() < DEPTH) || pop);
            if (bus.mod_en && !wr) m_ovf = 1'b1;
            if (pop) begin
                cur  = fq.pop_front();
                popped.push_back(cur);
                busy = SYMC;
            end else if (busy > 0) begin
                busy--;
            end
            if (wr) fq.push_back(bus.dmod);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        int   idx;
        logic eb;
        if (chk_on) begin
            eb = 1'b0;
            if (busy > 0) begin
                idx = (SYMC - busy) / CLK_DIV;
                eb  = cur[4 - idx];
            end
            chk("ser_valid", bus.ser_valid, busy > 0);
            chk("ser_out", bus.ser_out, eb);
            chk("sym_start", bus.sym_start, busy == SYMC);
            chk("level", bus.level, fq.size());
            chk("full", bus.full, fq.size() == DEPTH);
            chk("overflow", bus.overflow, m_ovf);
            chk("level_bound", bus.level <= DEPTH, 1);
        end
    end

    initial begin
        logic [9:0]  b10;
        logic [19:0] b20;
        logic [19:0] s20;
        int          cnt;
        bit          burst;

        rst        = 1'b1;
        bus.mod_en = 1'b1;
        bus.dmod   = 5'h1F;
        repeat (3) tick();
        chk_on = 1'b1;
        chk("rst_level", bus.level, 0);
        chk("rst_valid", bus.ser_valid, 0);
        chk("rst_out", bus.ser_out, 0);
        chk("rst_start", bus.sym_start, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst        = 1'b0;
        bus.mod_en = 1'b0;
        repeat (6) tick();

        // Single symbol 10110
        bus.dmod   = 5'b10110;
        bus.mod_en = 1'b1;
        tick();
        bus.mod_en = 1'b0;
        chk("t1_level", bus.level, 1);
        tick();
        b10 = '0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            b10 = {b10[8:0], bus.ser_out};
            cnt += int'(bus.sym_start);
            if (i == 0) chk("t1_start0", bus.sym_start, 1);
            tick();
        end
        chk("t1_bits", b10, 10'b1100111100);
        chk("t1_starts", cnt, 1);
        chk("t1_idle", bus.ser_valid, 0);
        repeat (3) tick();

        // Back-to-back 1F then 00
        bus.dmod   = 5'h1F;
        bus.mod_en = 1'b1;
        tick();
        bus.dmod = 5'h00;
        tick();
        bus.mod_en = 1'b0;
        b20 = '0;
        s20 = '0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            b20 = {b20[18:0], bus.ser_out};
            s20 = {s20[18:0], bus.sym_start};
            cnt += int'(bus.ser_valid);
            tick();
        end
        chk("t2_bits", b20, 20'hFFC00);
        chk("t2_starts", s20, 20'h80200);
        chk("t2_valid", cnt, 20);
        chk("t2_idle", bus.ser_valid, 0);
        repeat (3) tick();

        // Overflow: ten writes 0..9, value 9 dropped
        popped.delete();
        for (int v = 0; v < 10; v++) begin
            bus.dmod   = 5'(v);
            bus.mod_en = 1'b1;
            tick();
        end
        bus.mod_en = 1'b0;
        chk("t3_ovf", bus.overflow, 1);
        chk("t3_level", bus.level, 8);
        chk("t3_full", bus.full, 1);
        chk("t3_model_lvl", fq.size(), 8);
        repeat (9 * SYMC + 5) tick();
        chk("t3_npop", popped.size(), 9);
        for (int i = 0; i < 9 && i < popped.size(); i++)
            chk("t3_order", popped[i], i);
        chk("t3_sticky", bus.overflow, 1);
        chk("t3_drained", bus.level, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_ovf_clr", bus.overflow, 0);

        // Full FIFO written in the same cycle as a pop
        for (int v = 0; v < 9; v++) begin
            bus.dmod   = 5'(v + 16);
            bus.mod_en = 1'b1;
            tick();
        end
        bus.mod_en = 1'b0;
        chk("t4_full0", bus.full, 1);
        for (int k = 0; k < 40 && busy != 1; k++) tick();
        chk("t4_wait", busy == 1, 1);
        bus.dmod   = 5'h0A;
        bus.mod_en = 1'b1;
        tick();
        bus.mod_en = 1'b0;
        chk("t4_level", bus.level, DEPTH);
        chk("t4_full", bus.full, 1);
        chk("t4_ovf", bus.overflow, 0);
        repeat (9 * SYMC + 5) tick();

        // Reset during bit 2 of 5'h15 with three queued
        bus.dmod   = 5'h15;
        bus.mod_en = 1'b1;
        tick();
        for (int v = 1; v < 4; v++) begin
            bus.dmod = 5'(v);
            tick();
        end
        bus.mod_en = 1'b0;
        repeat (2) tick();
        chk("t5_mid_valid", bus.ser_valid, 1);
        chk("t5_mid_bit2", bus.ser_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_out", bus.ser_out, 0);
        chk("t5_valid", bus.ser_valid, 0);
        chk("t5_start", bus.sym_start, 0);
        chk("t5_level", bus.level, 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt += int'(bus.ser_valid);
        end
        chk("t5_silent", cnt, 0);

        // Random bursts
        burst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) burst = !burst;
            bus.mod_en = burst || ($urandom_range(0, 7) == 0);
            bus.dmod   = 5'($urandom);
            tick();
        end
        bus.mod_en = 1'b0;
        repeat ((DEPTH + 1) * SYMC + 5) tick();
        chk("t6_level", bus.level, 0);
        chk("t6_idle", bus.ser_valid, 0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
